td4_sequencer: RTL and testbench

TD4_SEQUENCER -- requirements
Module: td4_sequencer

---
 rtl/td4_seq_pkg.sv | 18 +
 rtl/td4_prog_mem.sv | 32 +++
 rtl/td4_sequencer.sv | 138 +++++++++++++
 tb/tb_td4_sequencer.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/td4_seq_pkg.sv
// Shared definitions for the TD4 program sequencer.
// Holds the sequencer state encoding and the program-memory geometry
// used by the top level and the program memory.
package td4_seq_pkg;

    localparam int PROG_DEPTH = 16;
    localparam int INSTR_W    = 8;
    localparam int ADDR_W     = 4;

    // Encoding is visible on the state output, so values are fixed.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_STEP = 2'd3
    } seq_state_t;

endpackage

// File: rtl/td4_prog_mem.sv
// 16 x 8 program memory built as a register file.
// Ports:
//   clk    - write clock
//   we     - write enable, write happens on the rising edge
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - combinational read data (pre-edge contents)
// Contents are deliberately not reset so a loaded program survives rst_n.
module td4_prog_mem
    import td4_seq_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [PROG_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Reading before the edge means a same-cycle write returns old data.
    assign rdata = mem[raddr];

endmodule

// File: rtl/td4_sequencer.sv
// TD4 program sequencer: loads a 16-byte program, fetches instructions
// at the CPU program counter, and paces the CPU via a clock enable in
// free-run (divided) or single-step modes.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   cmd_load/run/step/halt- command requests, sampled as levels
//   load_valid, load_data - incoming program byte
//   load_ready            - a byte is accepted this cycle
//   load_done             - one-cycle pulse after the last byte is written
//   pc_in                 - CPU program counter
//   opcode, immediate     - fetched instruction fields (1-cycle latency)
//   cpu_ce                - CPU clock enable
//   state                 - current sequencer state
module td4_sequencer
    import td4_seq_pkg::*;
#(
    parameter int RUN_DIV = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_load,
    input  logic               cmd_run,
    input  logic               cmd_step,
    input  logic               cmd_halt,
    input  logic               load_valid,
    input  logic [INSTR_W-1:0] load_data,
    output logic               load_ready,
    output logic               load_done,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic [3:0]         opcode,
    output logic [3:0]         immediate,
    output logic               cpu_ce,
    output logic [1:0]         state
);

    localparam logic [7:0]        DIV_LAST  = 8'(RUN_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(PROG_DEPTH - 1);

    seq_state_t         cur_state;
    seq_state_t         next_state;
    logic [ADDR_W-1:0]  addr;
    logic [7:0]         divider;
    logic [INSTR_W-1:0] ir;
    logic [INSTR_W-1:0] rd_data;
    logic               mem_we;

    td4_prog_mem u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (addr),
        .wdata (load_data),
        .raddr (pc_in),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= ST_IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    always_comb begin
        next_state = cur_state;
        load_ready = 1'b0;
        mem_we     = 1'b0;
        cpu_ce     = 1'b0;
        case (cur_state)
            ST_IDLE: begin
                // Halt outranks everything and simply keeps us idle.
                if (cmd_halt) begin
                    next_state = ST_IDLE;
                end else if (cmd_load) begin
                    next_state = ST_LOAD;
                end else if (cmd_step) begin
                    next_state = ST_STEP;
                end else if (cmd_run) begin
                    next_state = ST_RUN;
                end
            end
            ST_LOAD: begin
                // Dropping ready during halt keeps the abort cycle write-free.
                load_ready = !cmd_halt;
                if (cmd_halt) begin
                    next_state = ST_IDLE;
                end else if (load_valid) begin
                    mem_we = 1'b1;
                    if (addr == ADDR_LAST) begin
                        next_state = ST_IDLE;
                    end
                end
            end
            ST_RUN: begin
                if (cmd_halt) begin
                    next_state = ST_IDLE;
                end else if (divider == DIV_LAST) begin
                    cpu_ce = 1'b1;
                end
            end
            ST_STEP: begin
                cpu_ce     = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            divider   <= '0;
            load_done <= 1'b0;
            ir        <= '0;
        end else begin
            if (cur_state == ST_IDLE && next_state == ST_LOAD) begin
                addr <= '0;
            end else if (mem_we) begin
                addr <= addr + 1'b1;
            end

            // Held at zero outside RUN so every entry starts a fresh count.
            if (cur_state != ST_RUN || divider == DIV_LAST) begin
                divider <= '0;
            end else begin
                divider <= divider + 8'd1;
            end

            load_done <= mem_we && (addr == ADDR_LAST);
            ir        <= rd_data;
        end
    end

    assign opcode    = ir[3:0];
    assign immediate = ir[7:4];
    assign state     = cur_state;

endmodule

// File: tb/tb_td4_sequencer.sv
module tb_td4_sequencer;

    localparam int RUN_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_load, cmd_run, cmd_step, cmd_halt;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_ready, load_done;
    logic [3:0] pc_in;
    logic [3:0] opcode, immediate;
    logic       cpu_ce;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    // Reference image of program memory.
    logic [7:0] model [16];

    td4_sequencer #(.RUN_DIV(RUN_DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_load   (cmd_load),
        .cmd_run    (cmd_run),
        .cmd_step   (cmd_step),
        .cmd_halt   (cmd_halt),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .load_done  (load_done),
        .pc_in      (pc_in),
        .opcode     (opcode),
        .immediate  (immediate),
        .cpu_ce     (cpu_ce),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_load = 0; cmd_run = 0; cmd_step = 0; cmd_halt = 0;
        load_valid = 0; load_data = 8'h00; pc_in = 4'd0;
        #12;
        checks++;
        if (state !== 2'd0 || cpu_ce !== 1'b0 || load_ready !== 1'b0 ||
            load_done !== 1'b0 || opcode !== 4'd0 || immediate !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: state=%0d ce=%0b rdy=%0b done=%0b op=%0h imm=%0h, need all 0",
                     state, cpu_ce, load_ready, load_done, opcode, immediate);
        end
        step_clk();
        rst_n = 1'b1;
        step_clk();
    endtask

    task automatic test_load_fixed();
        cmd_load = 1'b1;
        step_clk();
        cmd_load = 1'b0;
        checks++;
        if (state !== 2'd1) begin
            errors++;
            $display("FAIL load_enter: state=%0d need 1", state);
        end
        for (int i = 0; i < 16; i++) begin
            load_valid = 1'b1;
            load_data  = 8'h10 + 8'(i);
            #1;
            checks++;
            if (load_ready !== 1'b1) begin
                errors++;
                $display("FAIL load_ready[%0d]: got %0b need 1", i, load_ready);
            end
            step_clk();
            model[i] = 8'h10 + 8'(i);
            checks++;
            if (i < 15 && (load_done !== 1'b0 || state !== 2'd1)) begin
                errors++;
                $display("FAIL load_mid[%0d]: done=%0b state=%0d need 0/1", i, load_done, state);
            end else if (i == 15 && (load_done !== 1'b1 || state !== 2'd0)) begin
                errors++;
                $display("FAIL load_done_pulse: done=%0b state=%0d need 1/0", load_done, state);
            end
        end
        load_valid = 1'b0;
        step_clk();
        checks++;
        if (load_done !== 1'b0) begin
            errors++;
            $display("FAIL load_done_width: got %0b need 0", load_done);
        end
        pc_in = 4'd5;
        step_clk();
        checks++;
        if (opcode !== 4'd5 || immediate !== 4'd1) begin
            errors++;
            $display("FAIL fetch_pc5: op=%0h imm=%0h need 5/1", opcode, immediate);
        end
    endtask

    task automatic test_random_load();
        logic [7:0] d;
        cmd_load = 1'b1;
        step_clk();
        cmd_load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            // Random bubbles: no handshake, nothing written.
            while ($urandom_range(3) == 0) begin
                load_valid = 1'b0;
                load_data  = 8'($urandom);
                step_clk();
                checks++;
                if (state !== 2'd1 || load_done !== 1'b0) begin
                    errors++;
                    $display("FAIL load_bubble[%0d]: state=%0d done=%0b", i, state, load_done);
                end
            end
            d = 8'($urandom);
            load_valid = 1'b1;
            load_data  = d;
            pc_in      = 4'(i);
            step_clk();
            // Fetch of the address being written sees the previous byte.
            checks++;
            if ({immediate, opcode} !== model[i]) begin
                errors++;
                $display("FAIL read_old[%0d]: got %02h need %02h", i, {immediate, opcode}, model[i]);
            end
            model[i] = d;
        end
        load_valid = 1'b0;
        checks++;
        if (load_done !== 1'b1 || state !== 2'd0) begin
            errors++;
            $display("FAIL rload_done: done=%0b state=%0d need 1/0", load_done, state);
        end
        for (int p = 0; p < 16; p++) begin
            pc_in = 4'(p);
            step_clk();
            checks++;
            if ({immediate, opcode} !== model[p]) begin
                errors++;
                $display("FAIL rload_read[%0d]: got %02h need %02h", p, {immediate, opcode}, model[p]);
            end
        end
    endtask

    task automatic test_load_abort();
        logic [7:0] d;
        int done_seen;
        cmd_load = 1'b1;
        step_clk();
        cmd_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom);
            load_valid = 1'b1;
            load_data  = d;
            step_clk();
            model[i] = d;
        end
        cmd_halt   = 1'b1;
        load_valid = 1'b1;
        load_data  = ~model[3];
        step_clk();
        cmd_halt   = 1'b0;
        load_valid = 1'b0;
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL abort_state: state=%0d need 0", state);
        end
        done_seen = (load_done === 1'b1) ? 1 : 0;
        for (int k = 0; k < 3; k++) begin
            step_clk();
            if (load_done === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL abort_no_done: pulses=%0d need 0", done_seen);
        end
        for (int p = 0; p < 16; p++) begin
            pc_in = 4'(p);
            step_clk();
            checks++;
            if ({immediate, opcode} !== model[p]) begin
                errors++;
                $display("FAIL abort_read[%0d]: got %02h need %02h", p, {immediate, opcode}, model[p]);
            end
        end
    endtask

    task automatic test_run();
        int pulses[$];
        int bad_state;
        int late_ce;
        cmd_run = 1'b1;
        step_clk();
        cmd_run = 1'b0;
        bad_state = 0;
        for (int c = 0; c < 20; c++) begin
            cmd_load = 1'($urandom);
            cmd_step = 1'($urandom);
            #1;
            if (cpu_ce === 1'b1) pulses.push_back(c);
            if (state !== 2'd2) bad_state++;
            step_clk();
        end
        cmd_load = 1'b0;
        cmd_step = 1'b0;
        checks++;
        if (bad_state != 0) begin
            errors++;
            $display("FAIL run_state: %0d cycles not in RUN, need 0", bad_state);
        end
        checks++;
        if (pulses.size() != 20 / RUN_DIV) begin
            errors++;
            $display("FAIL run_count: got %0d pulses need %0d", pulses.size(), 20 / RUN_DIV);
        end else begin
            checks++;
            if (pulses[0] != RUN_DIV - 1) begin
                errors++;
                $display("FAIL run_first: cycle %0d need %0d", pulses[0], RUN_DIV - 1);
            end
            for (int k = 1; k < pulses.size(); k++) begin
                checks++;
                if (pulses[k] - pulses[k-1] != RUN_DIV) begin
                    errors++;
                    $display("FAIL run_spacing[%0d]: got %0d need %0d", k, pulses[k] - pulses[k-1], RUN_DIV);
                end
            end
        end
        // Cycles 20..22, then halt on cycle 23 which would otherwise pulse.
        for (int c = 20; c < 23; c++) step_clk();
        cmd_halt = 1'b1;
        #1;
        checks++;
        if (cpu_ce !== 1'b0) begin
            errors++;
            $display("FAIL run_halt_ce: got %0b need 0", cpu_ce);
        end
        step_clk();
        cmd_halt = 1'b0;
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL run_halt_state: state=%0d need 0", state);
        end
        late_ce = 0;
        for (int k = 0; k < 10; k++) begin
            if (cpu_ce === 1'b1) late_ce++;
            step_clk();
        end
        checks++;
        if (late_ce != 0) begin
            errors++;
            $display("FAIL run_after_halt: %0d pulses need 0", late_ce);
        end
    endtask

    task automatic test_priority();
        cmd_load = 1'b1; cmd_step = 1'b1; cmd_run = 1'b1;
        #1;
        step_clk();
        checks++;
        if (state !== 2'd1 || cpu_ce !== 1'b0) begin
            errors++;
            $display("FAIL prio: state=%0d ce=%0b need 1/0", state, cpu_ce);
        end
        cmd_load = 1'b0;
        step_clk();
        step_clk();
        checks++;
        if (state !== 2'd1 || cpu_ce !== 1'b0) begin
            errors++;
            $display("FAIL load_ignores_run_step: state=%0d ce=%0b need 1/0", state, cpu_ce);
        end
        cmd_step = 1'b0; cmd_run = 1'b0; cmd_halt = 1'b1;
        step_clk();
        cmd_halt = 1'b0;
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL prio_exit: state=%0d need 0", state);
        end
    endtask

    task automatic test_step();
        logic ce [6];
        int cnt;
        int adj;
        cmd_step = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step_clk();
            ce[k] = cpu_ce;
        end
        cmd_step = 1'b0;
        cnt = 0;
        adj = 0;
        for (int k = 0; k < 6; k++) begin
            if (ce[k] === 1'b1) cnt++;
            if (k > 0 && ce[k] === 1'b1 && ce[k-1] === 1'b1) adj++;
        end
        checks++;
        if (cnt != 3 || adj != 0 || ce[0] !== 1'b1) begin
            errors++;
            $display("FAIL step_pulses: count=%0d adjacent=%0d first=%0b need 3/0/1", cnt, adj, ce[0]);
        end
        step_clk();
        checks++;
        if (state !== 2'd0 || cpu_ce !== 1'b0) begin
            errors++;
            $display("FAIL step_idle: state=%0d ce=%0b need 0/0", state, cpu_ce);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] d;
        int done_seen;
        cmd_load = 1'b1;
        step_clk();
        cmd_load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            d = 8'($urandom);
            load_valid = 1'b1;
            load_data  = d;
            step_clk();
            model[i] = d;
        end
        load_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (state !== 2'd0 || load_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_load: state=%0d rdy=%0b need 0/0", state, load_ready);
        end
        step_clk();
        rst_n = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (load_done === 1'b1) done_seen++;
            step_clk();
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL rst_load_done: pulses=%0d need 0", done_seen);
        end
    endtask

    task automatic test_reset_mid_run();
        int late_ce;
        pc_in = 4'd7;
        cmd_run = 1'b1;
        step_clk();
        cmd_run = 1'b0;
        for (int c = 0; c < RUN_DIV - 1; c++) step_clk();
        checks++;
        if (cpu_ce !== 1'b1) begin
            errors++;
            $display("FAIL rst_run_pre: ce=%0b need 1", cpu_ce);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (cpu_ce !== 1'b0 || state !== 2'd0 || opcode !== 4'd0 || immediate !== 4'd0) begin
            errors++;
            $display("FAIL rst_run: ce=%0b state=%0d op=%0h imm=%0h need all 0",
                     cpu_ce, state, opcode, immediate);
        end
        step_clk();
        rst_n = 1'b1;
        late_ce = 0;
        for (int k = 0; k < 10; k++) begin
            if (cpu_ce === 1'b1 || state !== 2'd0) late_ce++;
            step_clk();
        end
        checks++;
        if (late_ce != 0) begin
            errors++;
            $display("FAIL rst_run_after: %0d bad cycles need 0", late_ce);
        end
        for (int p = 0; p < 16; p++) begin
            pc_in = 4'(p);
            step_clk();
            checks++;
            if ({immediate, opcode} !== model[p]) begin
                errors++;
                $display("FAIL rst_retain[%0d]: got %02h need %02h", p, {immediate, opcode}, model[p]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_fixed();
        test_random_load();
        test_load_abort();
        test_run();
        test_priority();
        test_step();
        test_reset_mid_load();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
